tx: RTL and testbench

TX -- requirements
Module: tx

---
 rtl/tx_if.sv | 24 ++
 rtl/tx.sv | 144 ++++++++++++++
 tb/tb_tx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_if.sv
// Port bundle for the DCSK transmitter.
// cb gives benches a sampled view of the chip outputs.
interface tx_if (
  input logic i_clk
);
  logic        i_arst;
  logic [15:0] i_seed;
  logic        i_load_seed;
  logic        i_send;
  logic [31:0] i_msg;
  logic [1:0]  i_sf;
  logic        o_tx;
  logic        o_is_sending;

  clocking cb @(posedge i_clk);
    input o_tx, o_is_sending;
  endclocking

  modport tx (
    input  i_clk, i_arst, i_seed, i_load_seed,
    input  i_send, i_msg, i_sf,
    output o_tx, o_is_sending
  );
endinterface

// File: rtl/tx.sv
// Binary DCSK transmitter: LFSR reference half, then data half per bit.
// Define TX_ASSERTIONS_EN to compile the built-in protocol assertions.
module tx (
  tx_if.tx bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REF  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] msg_q, msg_d;
  logic [1:0]  sf_q, sf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] ref_q, ref_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic [15:0] seed_eff, lfsr_cur, lfsr_nxt;
  logic [3:0]  last_cnt, cnt_inc;
  logic        half_end, frame_end, start, cur_bit;

  always_comb begin
    seed_eff  = (bus.i_seed == 16'h0) ? 16'h0001 : bus.i_seed;
    lfsr_cur  = (state_q == S_IDLE && bus.i_load_seed) ? seed_eff : lfsr_q;
    lfsr_nxt  = {lfsr_cur[0] ^ lfsr_cur[2] ^ lfsr_cur[3] ^ lfsr_cur[5],
                 lfsr_cur[15:1]};
    last_cnt  = 4'((5'd2 << sf_q) - 5'd1);
    cnt_inc   = cnt_q + 4'd1;
    half_end  = (cnt_q == last_cnt);
    cur_bit   = msg_q[~bit_q];
    frame_end = (state_q == S_DATA) && half_end && (bit_q == 5'd31);
    // A new frame may also start on the edge that ends the last chip
    start     = bus.i_send && ((state_q == S_IDLE) || frame_end);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    msg_d   = msg_q;
    sf_d    = sf_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ref_d   = ref_q;
    tx_d    = 1'b0;
    busy_d  = 1'b0;
    if (start) begin
      state_d  = S_REF;
      cnt_d    = 4'd0;
      bit_d    = 5'd0;
      msg_d    = bus.i_msg;
      sf_d     = bus.i_sf;
      tx_d     = lfsr_cur[0];
      ref_d[0] = lfsr_cur[0];
      lfsr_d   = lfsr_nxt;
      busy_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: lfsr_d = lfsr_cur;
        S_REF: begin
          busy_d = 1'b1;
          if (!half_end) begin
            cnt_d = cnt_inc;
            tx_d = lfsr_q[0];
            ref_d[cnt_inc] = lfsr_q[0];
            lfsr_d = lfsr_nxt;
          end else begin
            state_d = S_DATA;
            cnt_d = 4'd0;
            tx_d = ref_q[0] ~^ cur_bit;
          end
        end
        S_DATA: begin
          busy_d = 1'b1;
          if (!half_end) begin
            cnt_d = cnt_inc;
            tx_d = ref_q[cnt_inc] ~^ cur_bit;
          end else if (bit_q != 5'd31) begin
            state_d = S_REF;
            cnt_d = 4'd0;
            bit_d = bit_q + 5'd1;
            tx_d = lfsr_q[0];
            ref_d[0] = lfsr_q[0];
            lfsr_d = lfsr_nxt;
          end else begin
            state_d = S_IDLE;
            busy_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus.i_clk or posedge bus.i_arst) begin
    if (bus.i_arst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 16'h0001;
      msg_q   <= 32'h0;
      sf_q    <= 2'd0;
      cnt_q   <= 4'd0;
      bit_q   <= 5'd0;
      ref_q   <= 16'h0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      msg_q   <= msg_d;
      sf_q    <= sf_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ref_q   <= ref_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_tx         = tx_q;
  assign bus.o_is_sending = busy_q;

`ifdef TX_ASSERTIONS_EN
  logic [10:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (start) fcnt_d = 11'd1;
    else if (busy_d) fcnt_d = fcnt_q + 11'd1;
  end

  always_ff @(posedge bus.i_clk or posedge bus.i_arst) begin
    if (bus.i_arst) fcnt_q <= 11'd0;
    else fcnt_q <= fcnt_d;
  end

  a_idle_quiet: assert property (@(posedge bus.i_clk)
    disable iff (bus.i_arst) !busy_q |-> !tx_q);
  a_frame_len: assert property (@(posedge bus.i_clk)
    disable iff (bus.i_arst) frame_end |-> fcnt_q == (11'd128 << sf_q));
  a_lfsr_live: assert property (@(posedge bus.i_clk)
    disable iff (bus.i_arst) lfsr_q != 16'h0);
`endif
endmodule

// File: tb/tb_tx.sv
// Directed + random bench for the DCSK transmitter.
// Expected chips come from a reference LFSR/DCSK model via a scoreboard.
module tb_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  tx_if bus (.i_clk(clk));
  tx dut (.bus(bus));

  int ncmp = 0;
  int nfail = 0;

  bit          chip_q[$];
  int          len_q[$];
  logic [31:0] word_q[$];
  bit          fbuf[$];
  int          fcnt = 0;
  logic [15:0] m_lfsr = 16'h0001;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen(input logic [31:0] msg, input logic [1:0] sf);
    int h;
    bit r[16];
    h = 2 << sf;
    for (int b = 31; b >= 0; b--) begin
      for (int k = 0; k < h; k++) begin
        r[k] = m_lfsr[0];
        chip_q.push_back(r[k]);
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                  m_lfsr[15:1]};
      end
      for (int k = 0; k < h; k++)
        chip_q.push_back(msg[b] ? r[k] : ~r[k]);
    end
    len_q.push_back(64 * h);
    word_q.push_back(msg);
  endtask

  function automatic logic [31:0] demod(input int len);
    logic [31:0] w;
    int h, s, base;
    h = len / 64;
    w = '0;
    for (int b = 0; b < 32; b++) begin
      s = 0;
      base = b * 2 * h;
      for (int k = 0; k < h; k++)
        s += (fbuf[base + k] == fbuf[base + h + k]) ? 1 : 0;
      w[31 - b] = (s > h / 2);
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (bus.i_arst) begin
      check("rst_tx", bus.o_tx, 0);
      check("rst_busy", bus.o_is_sending, 0);
      chip_q.delete();
      len_q.delete();
      word_q.delete();
      fbuf.delete();
      fcnt = 0;
    end else if (bus.o_is_sending) begin
      if (len_q.size() == 0) begin
        check("extra_chip", bus.o_is_sending, 0);
      end else begin
        check("chip", bus.o_tx, chip_q.pop_front());
        fbuf.push_back(bus.o_tx);
        fcnt++;
        if (fcnt == len_q[0]) begin
          check("word", demod(fcnt), word_q.pop_front());
          void'(len_q.pop_front());
          fbuf.delete();
          fcnt = 0;
        end
      end
    end else begin
      check("idle_tx", bus.o_tx, 0);
      if (fcnt != 0) begin
        check("frame_len", fcnt, len_q[0]);
        fbuf.delete();
        fcnt = 0;
      end
    end
  end

  task automatic send(input logic [31:0] msg, input logic [1:0] sf,
                      input logic ld, input logic [15:0] seed);
    bus.i_send = 1'b1;
    bus.i_msg = msg;
    bus.i_sf = sf;
    bus.i_load_seed = ld;
    bus.i_seed = seed;
    if (ld) m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
    gen(msg, sf);
    @(posedge clk);
    #1;
    bus.i_send = 1'b0;
    bus.i_load_seed = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_is_sending && n < 1200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", bus.o_is_sending, 0);
  endtask

  task automatic first8();
    logic [7:0] pat = 8'b1010_0011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("first8", bus.o_tx, pat[7 - i]);
    end
  endtask

  initial begin
    logic [31:0] m;
    logic [1:0]  s;
    bus.i_arst = 1'b1;
    bus.i_seed = 16'h0;
    bus.i_load_seed = 1'b0;
    bus.i_send = 1'b0;
    bus.i_msg = 32'h0;
    bus.i_sf = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    bus.i_arst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_busy", bus.o_is_sending, 0);

    send(32'h8000_0000, 2'd0, 1'b1, 16'h0001);
    first8();
    wait_idle();

    send(32'h8000_0000, 2'd0, 1'b1, 16'h0000);
    first8();
    wait_idle();

    bus.i_send = 1'b1;
    bus.i_msg = 32'hA5C3_0F96;
    bus.i_sf = 2'd1;
    gen(32'hA5C3_0F96, 2'd1);
    @(posedge clk);
    #1;
    repeat (255) @(posedge clk);
    #1;
    bus.i_msg = 32'h1234_ABCD;
    bus.i_sf = 2'd3;
    gen(32'h1234_ABCD, 2'd3);
    @(posedge clk);
    #1;
    bus.i_send = 1'b0;
    @(negedge clk);
    check("b2b_nogap", bus.o_is_sending, 1);
    wait_idle();

    send(32'h0F0F_3C3C, 2'd2, 1'b0, 16'h0);
    repeat (20) @(posedge clk);
    #1;
    bus.i_load_seed = 1'b1;
    bus.i_seed = 16'hBEEF;
    bus.i_msg = 32'hF0F0_C3C3;
    bus.i_sf = 2'd0;
    repeat (30) @(posedge clk);
    #1;
    bus.i_load_seed = 1'b0;
    wait_idle();

    send(32'hDEAD_BEEF, 2'd2, 1'b0, 16'h0);
    repeat (50) @(posedge clk);
    #1;
    bus.i_arst = 1'b1;
    #1;
    check("arst_tx", bus.o_tx, 0);
    check("arst_busy", bus.o_is_sending, 0);
    m_lfsr = 16'h0001;
    @(posedge clk);
    #1;
    bus.i_arst = 1'b0;
    send(32'h8000_0000, 2'd0, 1'b0, 16'h0);
    first8();
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      m = $urandom;
      s = 2'($urandom_range(0, 3));
      send(m, s, 1'b0, 16'h0);
      wait_idle();
      repeat ($urandom_range(0, 9)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("chips_left", chip_q.size(), 0);
    check("words_left", word_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
